// File: rtl/pad_poll_ctrl_pkg.sv
// pad_poll_pkg: shared types and defaults for the gamepad poll sequencer.
//   state_t  - poll FSM states
//   DEF_*    - default parameter values
//   max2     - elaboration-time max, used to size the duration counter
package pad_poll_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_HALF_PERIOD = 300;
  localparam int DEF_LATCH_LEN   = 600;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SAMPLE,
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pad_poll_ctrl_if.sv
// pad_poll_ctrl_if: bundles the poll request, the pad pins and the
// published button word.
//   master - controller side (drives pad pins, busy, buttons, valid)
//   slave  - requester / pad side
interface pad_poll_ctrl_if
  import pad_poll_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             pad_data;
  logic             pad_latch;
  logic             pad_clk;
  logic             busy;
  logic [WIDTH-1:0] buttons;
  logic             valid;

  modport master (
    input  start, pad_data,
    output pad_latch, pad_clk, busy, buttons, valid
  );

  modport slave (
    output start, pad_data,
    input  pad_latch, pad_clk, busy, buttons, valid
  );
endinterface

// File: rtl/pad_poll_ctrl_sipo.sv
// pad_sipo: WIDTH-bit serial-in/parallel-out capture register.
//   clock, reset - system clock, async active-high reset (clears to 0)
//   in           - serial bit, enters at the LSB
//   ld_en        - shift enable
//   q            - parallel contents; first bit shifted ends up in the MSB
module pad_sipo #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             ld_en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      q <= '0;
    else if (ld_en) q <= {q[WIDTH-2:0], in};
  end

endmodule

// File: rtl/pad_poll_ctrl.sv
// pad_poll_ctrl: serial gamepad poll sequencer.
// On start (in IDLE) it raises the pad latch, then clocks WIDTH serial bits
// out of the pad, inverting them (pad is active-low) into a SIPO register,
// and publishes the word on buttons with a one-cycle valid pulse.
//   clock, reset - system clock, async active-high reset
//   bus.start    - poll request, only looked at in IDLE
//   bus.pad_data - raw serial data from the pad (async, active-low)
//   bus.pad_latch, bus.pad_clk - pad strobes, decoded from the state register
//   bus.busy     - poll in progress
//   bus.buttons  - last completed poll, active-high
//   bus.valid    - one-cycle pulse when buttons updates
module pad_poll_ctrl
  import pad_poll_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int LATCH_LEN   = DEF_LATCH_LEN
) (
  input logic             clock,
  input logic             reset,
  pad_poll_ctrl_if.master bus
);

  localparam int CW = $clog2(max2(LATCH_LEN, HALF_PERIOD) + 1);
  localparam int BW = $clog2(WIDTH);

  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_LEN - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [1:0]       sync;
  logic             sync_data;
  logic [CW-1:0]    dur;
  logic [BW-1:0]    bit_cnt;
  logic             ld_en;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] buttons;
  logic             valid;

  // Two-flop synchronizer; resets to the pad's idle (released) level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], bus.pad_data};
  end
  assign sync_data = sync[1];

  pad_sipo #(.WIDTH(WIDTH)) u_sipo (
    .clock (clock),
    .reset (reset),
    .in    (~sync_data),
    .ld_en (ld_en),
    .q     (cap)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dur     <= '0;
      bit_cnt <= '0;
      buttons <= '0;
      valid   <= 1'b0;
    end else begin
      state <= state_nx;
      // Duration restarts on every state change; only timed states count.
      if (state_nx != state)
        dur <= '0;
      else if (state == LATCH || state == CLK_LO || state == CLK_HI)
        dur <= dur + CW'(1);
      if (state == LATCH)       bit_cnt <= '0;
      else if (state == SAMPLE) bit_cnt <= bit_cnt + BW'(1);
      valid <= (state == DONE);
      if (state == DONE) buttons <= cap;
    end
  end

  always_comb begin
    state_nx = state;
    ld_en    = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nx = LATCH;
      LATCH:  if (dur == LATCH_LAST) state_nx = SAMPLE;
      SAMPLE: begin
        ld_en    = 1'b1;
        state_nx = (bit_cnt == BIT_LAST) ? DONE : CLK_LO;
      end
      CLK_LO: if (dur == HALF_LAST) state_nx = CLK_HI;
      CLK_HI: if (dur == HALF_LAST) state_nx = SAMPLE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.pad_latch = (state == LATCH);
  assign bus.pad_clk   = (state != CLK_LO);
  assign bus.busy      = (state != IDLE);
  assign bus.buttons   = buttons;
  assign bus.valid     = valid;

endmodule

// File: tb/tb_pad_poll_ctrl.sv
module tb_pad_poll_ctrl;
  import pad_poll_pkg::*;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int L   = 3;
  localparam int LAT = L + W + 2*H*(W-1) + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  pad_poll_ctrl_if #(.WIDTH(W)) pif();

  pad_poll_ctrl #(.WIDTH(W), .HALF_PERIOD(H), .LATCH_LEN(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (pif.master)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  // Pad model: presents bit 0 when latched, next bit on each pad_clk fall.
  logic [W-1:0] pad_pins = '1;
  logic         pad_q    = 1'b1;
  int           pk       = 0;
  assign pif.pad_data = pad_q;
  always @(posedge pif.pad_latch or negedge pif.pad_clk) begin
    if (pif.pad_latch) begin
      pk    = 0;
      pad_q = pad_pins[0];
    end else begin
      pk = pk + 1;
      if (pk < W) pad_q = pad_pins[pk];
    end
  end

  // Strobe monitor: latch cycles, pad_clk low cycles, low pulses, bad widths.
  int   lat_cy = 0, low_cy = 0, pulses = 0, bad_pulses = 0, run = 0;
  logic prev_clk = 1'b1;
  always @(negedge clock) begin
    if (pif.pad_latch) lat_cy++;
    if (!pif.pad_clk) begin
      low_cy++;
      run++;
      if (prev_clk) pulses++;
    end else begin
      if (!prev_clk && run != H) bad_pulses++;
      run = 0;
    end
    prev_clk = pif.pad_clk;
  end

  // Reference: k-th serial bit (active-low) lands in buttons[W-1-k].
  function automatic logic [W-1:0] exp_btn(input logic [W-1:0] pins);
    logic [W-1:0] e;
    for (int k = 0; k < W; k++) e[W-1-k] = ~pins[k];
    return e;
  endfunction

  task automatic run_poll(input logic [W-1:0] pins, output int lat,
                          output logic [W-1:0] btn, output int vlen,
                          output logic busy_v, output logic busy_pre,
                          output int d_lat, output int d_pul, output int d_low,
                          output int d_bad, output bit to);
    int e0, s_lat, s_pul, s_low, s_bad, n;
    pad_pins = pins;
    to = 0; vlen = 0; n = 0; busy_pre = 1'b0;
    @(negedge clock);
    s_lat = lat_cy; s_pul = pulses; s_low = low_cy; s_bad = bad_pulses;
    pif.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clock);
    pif.start = 1'b0;
    forever begin
      if (pif.valid) break;
      if (n >= 200) begin to = 1; break; end
      busy_pre = pif.busy;
      @(negedge clock);
      n++;
    end
    lat = cyc - e0;
    btn = pif.buttons;
    busy_v = pif.busy;
    while (pif.valid && vlen < 4) begin vlen++; @(negedge clock); end
    d_lat = lat_cy - s_lat; d_pul = pulses - s_pul;
    d_low = low_cy - s_low; d_bad = bad_pulses - s_bad;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (pif.pad_latch !== 1'b0 || pif.pad_clk !== 1'b1 || pif.busy !== 1'b0 ||
        pif.valid !== 1'b0 || pif.buttons !== '0) begin
      n_fail++;
      $display("FAIL reset_por: latch=%b clk=%b busy=%b valid=%b btn=%h want 0 1 0 0 0",
               pif.pad_latch, pif.pad_clk, pif.busy, pif.valid, pif.buttons);
    end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    pad_pins = 4'b0000;
    pif.start = 1'b1;
    @(negedge clock); pif.start = 1'b0;
    @(negedge clock);
    n_tests++;
    if (pif.pad_latch !== 1'b1 || pif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prelatch: latch=%b busy=%b want 1 1", pif.pad_latch, pif.busy);
    end
    @(posedge clock); #2 reset = 1'b1;
    #1;
    n_tests++;
    if (pif.pad_latch !== 1'b0 || pif.pad_clk !== 1'b1 || pif.busy !== 1'b0 ||
        pif.valid !== 1'b0 || pif.buttons !== '0) begin
      n_fail++;
      $display("FAIL reset_async: latch=%b clk=%b busy=%b valid=%b btn=%h want 0 1 0 0 0",
               pif.pad_latch, pif.pad_clk, pif.busy, pif.valid, pif.buttons);
    end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single;
    int lat, vlen, dl, dp, dlo, db; logic [W-1:0] btn; logic bv, bp; bit to;
    logic [W-1:0] pins;
    pins = 4'b1010;   // serial order 0,1,0,1
    run_poll(pins, lat, btn, vlen, bv, bp, dl, dp, dlo, db, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %0d want 0", to); end
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (btn !== exp_btn(pins)) begin n_fail++; $display("FAIL single_buttons: got %b want %b", btn, exp_btn(pins)); end
    n_tests++; if (vlen !== 1) begin n_fail++; $display("FAIL single_valid_len: got %0d want 1", vlen); end
    n_tests++; if (bv !== 1'b0 || bp !== 1'b1) begin n_fail++; $display("FAIL single_busy: at_valid=%b before=%b want 0 1", bv, bp); end
    n_tests++; if (dl !== L) begin n_fail++; $display("FAIL single_latch_len: got %0d want %0d", dl, L); end
    n_tests++; if (dp !== W-1) begin n_fail++; $display("FAIL single_clk_pulses: got %0d want %0d", dp, W-1); end
    n_tests++; if (dlo !== H*(W-1) || db !== 0) begin n_fail++; $display("FAIL single_clk_width: low=%0d bad=%0d want %0d 0", dlo, db, H*(W-1)); end
    n_tests++; if (pif.buttons !== exp_btn(pins)) begin n_fail++; $display("FAIL single_hold: got %b want %b", pif.buttons, exp_btn(pins)); end
  endtask

  task automatic test_ignored_start;
    int e0, n, lat, nval; logic [W-1:0] pins;
    pins = W'($urandom);
    pad_pins = pins;
    @(negedge clock); pif.start = 1'b1; e0 = cyc + 1;
    @(negedge clock); pif.start = 1'b0;
    n = 0;
    while (pif.pad_clk && n < 50) begin @(negedge clock); n++; end
    pif.start = 1'b1;
    @(negedge clock); pif.start = 1'b0;
    n = 0;
    while (!pif.valid && n < 200) begin @(negedge clock); n++; end
    lat = cyc - e0;
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL ignored_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (pif.buttons !== exp_btn(pins)) begin n_fail++; $display("FAIL ignored_buttons: got %b want %b", pif.buttons, exp_btn(pins)); end
    nval = 0;
    for (int i = 0; i < 3*LAT; i++) begin @(negedge clock); if (pif.valid) nval++; end
    n_tests++; if (nval !== 0) begin n_fail++; $display("FAIL ignored_extra_valid: got %0d want 0", nval); end
  endtask

  task automatic test_back_to_back;
    int e0, t1, t2, n, nval; logic [W-1:0] b1, b2;
    pad_pins = '0;
    @(negedge clock); pif.start = 1'b1; e0 = cyc + 1;
    @(negedge clock);
    n = 0;
    while (!pif.valid && n < 200) begin @(negedge clock); n++; end
    t1 = cyc; b1 = pif.buttons;
    pad_pins = '1;
    @(negedge clock);
    n = 0;
    while (!pif.valid && n < 200) begin @(negedge clock); n++; end
    t2 = cyc; b2 = pif.buttons;
    pif.start = 1'b0;
    n_tests++; if (t1 - e0 !== LAT) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want %0d", t1 - e0, LAT); end
    n_tests++; if (t2 - t1 !== LAT + 1) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", t2 - t1, LAT + 1); end
    n_tests++; if (b1 !== 4'hF) begin n_fail++; $display("FAIL b2b_first_buttons: got %h want f", b1); end
    n_tests++; if (b2 !== 4'h0) begin n_fail++; $display("FAIL b2b_second_buttons: got %h want 0", b2); end
    nval = 0;
    @(negedge clock);
    for (int i = 0; i < 2*LAT; i++) begin if (pif.valid) nval++; @(negedge clock); end
    n_tests++; if (nval !== 0 || pif.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_stop: valids=%0d busy=%b want 0 0", nval, pif.busy); end
  endtask

  task automatic test_reset_abort;
    int lat, vlen, dl, dp, dlo, db, s_pul, n, nval; logic [W-1:0] btn, pins; logic bv, bp; bit to;
    pins = W'($urandom_range(0, (1 << W) - 2));   // never all released
    run_poll(pins, lat, btn, vlen, bv, bp, dl, dp, dlo, db, to);
    n_tests++; if (btn !== exp_btn(pins)) begin n_fail++; $display("FAIL abort_pre_buttons: got %b want %b", btn, exp_btn(pins)); end
    pad_pins = W'($urandom);
    s_pul = pulses;
    @(negedge clock); pif.start = 1'b1;
    @(negedge clock); pif.start = 1'b0;
    n = 0;
    while (!(pulses - s_pul >= 2 && pif.pad_clk) && n < 100) begin @(negedge clock); n++; end
    n_tests++; if (n >= 100) begin n_fail++; $display("FAIL abort_reach_clk_hi: waited %0d cycles, limit 100", n); end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (pif.buttons !== '0 || pif.busy !== 1'b0 || pif.valid !== 1'b0 || pif.pad_clk !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset_vals: btn=%h busy=%b valid=%b clk=%b want 0 0 0 1",
               pif.buttons, pif.busy, pif.valid, pif.pad_clk);
    end
    @(negedge clock); reset = 1'b0;
    nval = 0;
    for (int i = 0; i < LAT + 5; i++) begin @(negedge clock); if (pif.valid) nval++; end
    n_tests++; if (nval !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d want 0", nval); end
    pins = W'($urandom);
    run_poll(pins, lat, btn, vlen, bv, bp, dl, dp, dlo, db, to);
    n_tests++; if (lat !== LAT || to) begin n_fail++; $display("FAIL abort_new_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (btn !== exp_btn(pins)) begin n_fail++; $display("FAIL abort_new_buttons: got %b want %b", btn, exp_btn(pins)); end
  endtask

  task automatic test_random;
    int lat, vlen, dl, dp, dlo, db; logic [W-1:0] btn, pins; logic bv, bp; bit to;
    for (int it = 0; it < 8; it++) begin
      if (it == 0)      pins = '1;
      else if (it == 1) pins = '0;
      else              pins = W'($urandom);
      run_poll(pins, lat, btn, vlen, bv, bp, dl, dp, dlo, db, to);
      n_tests++; if (btn !== exp_btn(pins)) begin n_fail++; $display("FAIL random_buttons[%0d]: pins=%b got %b want %b", it, pins, btn, exp_btn(pins)); end
      n_tests++; if (lat !== LAT || vlen !== 1 || to) begin n_fail++; $display("FAIL random_timing[%0d]: lat=%0d vlen=%0d want %0d 1", it, lat, vlen, LAT); end
    end
  endtask

  initial begin
    pif.start = 1'b0;
    test_reset;
    test_single;
    test_ignored_start;
    test_back_to_back;
    test_reset_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
